// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction sequencer: state indices,
// arithmetic datapath codes, the multiply/divide mode and a one-hot helper.
package ctrl_pkg;

  localparam int NUM_STATES = 16;

  // State indices; bit position of each state in the one-hot output
  localparam logic [3:0] S_IF0     = 4'd0;
  localparam logic [3:0] S_IF1     = 4'd1;
  localparam logic [3:0] S_FF0     = 4'd2;
  localparam logic [3:0] S_FF1     = 4'd3;
  localparam logic [3:0] S_FF2     = 4'd4;
  localparam logic [3:0] S_TF0     = 4'd5;
  localparam logic [3:0] S_TF1     = 4'd6;
  localparam logic [3:0] S_EX0     = 4'd7;
  localparam logic [3:0] S_EX1     = 4'd8;
  localparam logic [3:0] S_IT0     = 4'd9;
  localparam logic [3:0] S_IT1     = 4'd10;
  localparam logic [3:0] S_IT2     = 4'd11;
  localparam logic [3:0] S_AR_INIT = 4'd12;
  localparam logic [3:0] S_AR_STEP = 4'd13;
  localparam logic [3:0] S_AR_FIX  = 4'd14;
  localparam logic [3:0] S_AR_DONE = 4'd15;

  // Arithmetic datapath command codes
  localparam logic [2:0] AR_IDLE    = 3'b000;
  localparam logic [2:0] AR_LOAD    = 3'b001;
  localparam logic [2:0] AR_MUL_OP  = 3'b010;
  localparam logic [2:0] AR_DIV_OP  = 3'b011;
  localparam logic [2:0] AR_RESTORE = 3'b100;
  localparam logic [2:0] AR_FINISH  = 3'b101;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

  function automatic logic [NUM_STATES-1:0] state_to_onehot(input logic [3:0] s);
    state_to_onehot = {{(NUM_STATES-1){1'b0}}, 1'b1} << s;
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Down-counter for the multiply/divide iterations: loads a start value,
// decrements on request and stops at zero instead of wrapping.
module iter_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/state_seq_ctrl.sv
// Instruction sequencer: fetch, operand fetches, execute, interrupt entry
// and a multi-cycle multiply/divide loop driven by iter_counter.
module state_seq_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ACK,
  input  logic             ITA,
  input  logic             FROM_D,
  input  logic             TO_D,
  input  logic             op_MUL,
  input  logic             op_DIV,
  input  logic             rem_neg,
  output logic [15:0]      state_oh,
  output logic [CNT_W-1:0] counter_q,
  output logic [2:0]       ar_ctrl,
  output logic             ar_busy
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  mode_t      mode_q;
  logic       arith;
  logic       cnt_zero;
  logic       cnt_load;
  logic       cnt_dec;

  assign arith = op_MUL | op_DIV;

  // Next-state selection; memory-wait states hold until ACK
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF0: state_d = S_IF1;
      S_IF1: begin
        if (ACK) begin
          if (FROM_D)     state_d = S_FF0;
          else if (TO_D)  state_d = S_TF0;
          else if (arith) state_d = S_AR_INIT;
          else            state_d = S_EX0;
        end
      end
      S_FF0: state_d = S_FF1;
      S_FF1: if (ACK) state_d = S_FF2;
      S_FF2: begin
        if (TO_D)       state_d = S_TF0;
        else if (arith) state_d = S_AR_INIT;
        else            state_d = S_EX0;
      end
      S_TF0: state_d = S_TF1;
      S_TF1: if (ACK) state_d = arith ? S_AR_INIT : S_EX0;
      S_EX0: state_d = S_EX1;
      S_EX1: state_d = ITA ? S_IT0 : S_IF0;
      S_IT0: state_d = S_IT1;
      S_IT1: if (ACK) state_d = S_IT2;
      S_IT2: state_d = S_IF0;
      S_AR_INIT: state_d = S_AR_STEP;
      S_AR_STEP: begin
        if (cnt_zero) begin
          state_d = ((mode_q == MODE_DIV) && rem_neg) ? S_AR_FIX : S_AR_DONE;
        end
      end
      S_AR_FIX:  state_d = S_AR_DONE;
      S_AR_DONE: state_d = S_EX0;
      default:   state_d = S_IF0;
    endcase
  end

  // State register; the mode is captured on the edge that enters AR_INIT
  // so operand-decode changes during the arithmetic loop cannot affect it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IF0;
      mode_q  <= MODE_MUL;
    end else begin
      state_q <= state_d;
      if (state_d == S_AR_INIT) begin
        mode_q <= op_MUL ? MODE_MUL : MODE_DIV;
      end
    end
  end

  assign cnt_load = (state_q == S_AR_INIT);
  assign cnt_dec  = (state_q == S_AR_STEP);

  iter_counter #(
    .CNT_W(CNT_W)
  ) u_iter_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_load),
    .load_val(CNT_W'(DATA_W - 1)),
    .dec     (cnt_dec),
    .count   (counter_q),
    .zero    (cnt_zero)
  );

  // Datapath command decoded from registered state and mode only
  always_comb begin
    ar_ctrl = AR_IDLE;
    case (state_q)
      S_AR_INIT: ar_ctrl = AR_LOAD;
      S_AR_STEP: ar_ctrl = (mode_q == MODE_MUL) ? AR_MUL_OP : AR_DIV_OP;
      S_AR_FIX:  ar_ctrl = AR_RESTORE;
      S_AR_DONE: ar_ctrl = AR_FINISH;
      default:   ar_ctrl = AR_IDLE;
    endcase
  end

  assign state_oh = state_to_onehot(state_q);
  assign ar_busy  = (state_q >= S_AR_INIT);

endmodule
